// File: rtl/dragster_spi_responder.sv
// Dragster sensor configuration port stand-in: SPI mode-0 slave that
// writes {address, data} frames into a register bank with full-duplex readback.
module dragster_spi_responder #(
    parameter int unsigned ADDR_BITS   = 4,
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 wr_valid,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 frame_done,
    output logic                 frame_error,
    input  logic [ADDR_BITS-1:0] reg_rd_addr,
    output logic [7:0]           reg_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic ss_prev_q, ss_prev_d;

    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_in_q, shift_in_d;
    logic [7:0]           shift_out_q, shift_out_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 range_ok_q, range_ok_d;
    logic                 data_seen_q, data_seen_d;
    logic                 miso_q, miso_d;
    logic                 miso_oe_q, miso_oe_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_error_q, frame_error_d;
    logic [7:0]           reg_rd_data_q, reg_rd_data_d;
    logic [7:0]           bank_q [DEPTH];
    logic [7:0]           bank_d [DEPTH];

    logic                 sclk_s, ss_s, mosi_s;
    logic                 sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [7:0]           shift_in_next;
    logic                 range_ok_new;
    logic [ADDR_BITS-1:0] addr_new;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [7:0]           load_val;
    logic [7:0]           next_val;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    assign shift_in_next = {shift_in_q[6:0], mosi_s};
    assign range_ok_new  = (shift_in_next >> ADDR_BITS) == 8'h00;
    assign addr_new      = shift_in_next[ADDR_BITS-1:0];
    assign addr_inc      = addr_q + ADDR_BITS'(1);
    assign load_val      = bank_q[addr_new];
    assign next_val      = bank_q[addr_inc];

    // Synchronizer shift and edge-history next values
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
    end

    // Next-state logic of the frame FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) state_d = ADDR;
            end
            ADDR: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise && bit_cnt_q == 3'd7) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ss_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output values driven by the FSM state and SPI edges
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_in_d    = shift_in_q;
        shift_out_d   = shift_out_q;
        addr_d        = addr_q;
        range_ok_d    = range_ok_q;
        data_seen_d   = data_seen_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        wr_valid_d    = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        reg_rd_data_d = bank_q[reg_rd_addr];
        bank_d        = bank_q;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    bit_cnt_d   = 3'd0;
                    shift_in_d  = 8'h00;
                    shift_out_d = 8'h00;
                    range_ok_d  = 1'b0;
                    data_seen_d = 1'b0;
                    miso_d      = 1'b0;
                    miso_oe_d   = 1'b1;
                end
            end
            ADDR: begin
                if (ss_rise) begin
                    miso_d        = 1'b0;
                    miso_oe_d     = 1'b0;
                    frame_error_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_in_d = shift_in_next;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d      = addr_new;
                        range_ok_d  = range_ok_new;
                        shift_out_d = range_ok_new ? load_val : 8'h00;
                        miso_d      = shift_out_d[7];
                    end
                end
            end
            DATA: begin
                if (ss_rise) begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (bit_cnt_q != 3'd0) begin
                        frame_error_d = 1'b1;
                    end else if (data_seen_q) begin
                        frame_done_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_in_d = shift_in_next;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (range_ok_q) begin
                            bank_d[addr_q] = shift_in_next;
                            wr_valid_d     = 1'b1;
                            wr_addr_d      = addr_q;
                            wr_data_d      = shift_in_next;
                        end
                        addr_d      = addr_inc;
                        data_seen_d = 1'b1;
                        shift_out_d = range_ok_q ? next_val : 8'h00;
                        miso_d      = shift_out_d[7];
                    end
                end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                    // The MSB is already on miso at the byte boundary,
                    // so the fall right after it must not shift.
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                    miso_d      = shift_out_q[6];
                end
            end
            default: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sclk_sync_q   <= '0;
            // Select resets to "asserted" so a low ss_n at release is
            // not taken as a frame start; it must rise and fall first.
            ss_sync_q     <= '0;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            ss_prev_q     <= 1'b0;
            bit_cnt_q     <= 3'd0;
            shift_in_q    <= 8'h00;
            shift_out_q   <= 8'h00;
            addr_q        <= '0;
            range_ok_q    <= 1'b0;
            data_seen_q   <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 8'h00;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            reg_rd_data_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            ss_prev_q     <= ss_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_in_q    <= shift_in_d;
            shift_out_q   <= shift_out_d;
            addr_q        <= addr_d;
            range_ok_q    <= range_ok_d;
            data_seen_q   <= data_seen_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            reg_rd_data_q <= reg_rd_data_d;
            bank_q        <= bank_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign reg_rd_data = reg_rd_data_q;

endmodule
